operand_route_unit: RTL and testbench

- Registered, handshaked successor to the combinational operand muxes and writeback demux, parametrised in register count and word width.
- Selects ALU side-A/side-B operands (register, immediate or zero) with same-cycle writeback bypass, buffers them in a 2-entry skid stage, and registers the writeback demux into one-hot write enables.
- Sits between the register file and the ALU.

---
 rtl/tau_route_pkg.sv | 40 ++++
 rtl/operand_skid_buffer.sv | 73 +++++++
 rtl/operand_route_unit.sv | 132 +++++++++++++
 tb/tb_operand_route_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tau_route_pkg.sv
// Shared types and helpers for the operand route unit: selector
// classification and one-hot write-enable generation.
package tau_route_pkg;

  // Upper bound on the register count that onehot() can encode.
  localparam int MAX_REGS = 256;

  typedef enum logic [1:0] {
    SEL_REG     = 2'd0,
    SEL_IMM     = 2'd1,
    SEL_ILLEGAL = 2'd2
  } sel_kind_e;

  // Classify a selector: below num_regs is a register, exactly num_regs is
  // the immediate, anything above is illegal. Unsigned compare.
  function automatic sel_kind_e sel_kind(input logic [31:0] sel,
                                         input logic [31:0] num_regs);
    sel_kind_e kind;
    if (sel < num_regs) begin
      kind = SEL_REG;
    end else if (sel == num_regs) begin
      kind = SEL_IMM;
    end else begin
      kind = SEL_ILLEGAL;
    end
    return kind;
  endfunction

  // One-hot vector with bit idx set; all zero when idx is out of range.
  function automatic logic [MAX_REGS-1:0] onehot(input logic [31:0] idx,
                                                 input logic [31:0] num_regs);
    logic [MAX_REGS-1:0] vec;
    vec = '0;
    if (idx < num_regs) begin
      vec = MAX_REGS'(1) << idx;
    end
    return vec;
  endfunction

endpackage

// File: rtl/operand_skid_buffer.sv
// Two-entry valid/ready register slice. The main register drives the
// output; the skid register absorbs one beat while the consumer stalls.
// in_ready is taken straight from a flop so the upstream never sees a
// combinational path from out_ready.
module operand_skid_buffer #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              accept;
  logic              consume;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  // Next-state: refill main from skid first, otherwise from the input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid && !skid_valid_q;
    consume      = main_valid_q && out_ready;
    if (consume) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no new beat can arrive this cycle.
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  // State registers; reset empties both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/operand_route_unit.sv
// Operand routing between register file and ALU: selects side-A/side-B
// operands (register, immediate or zero) with same-cycle writeback bypass,
// buffers them through a 2-entry skid slice, and registers the writeback
// demux into one-hot write enables.
module operand_route_unit
  import tau_route_pkg::*;
#(
  parameter  int WORD_SIZE = 8,
  parameter  int NUM_REGS  = 8,
  localparam int SEL_W     = $clog2(NUM_REGS) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REGS*WORD_SIZE-1:0] regs_flat,
  input  logic [WORD_SIZE-1:0]          imm,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SEL_W-1:0]              sel_a,
  input  logic [SEL_W-1:0]              sel_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_SIZE-1:0]          op_a,
  output logic [WORD_SIZE-1:0]          op_b,
  output logic                          sel_err,
  input  logic                          wb_valid,
  input  logic [SEL_W-1:0]              wb_sel,
  input  logic [WORD_SIZE-1:0]          wb_data,
  output logic [NUM_REGS-1:0]           wb_we,
  output logic [WORD_SIZE-1:0]          wb_data_q,
  output logic                          wb_err
);

  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam int          BEAT_W     = 2 * WORD_SIZE + 1;
  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  logic [WORD_SIZE-1:0] regs_arr [NUM_REGS];
  sel_kind_e            wb_kind;
  logic                 wb_hit;
  logic [WORD_SIZE:0]   res_a, res_b;
  logic [WORD_SIZE-1:0] op_a_d, op_b_d;
  logic                 sel_err_d;
  logic [BEAT_W-1:0]    beat_out;
  logic [NUM_REGS-1:0]  wb_we_q, wb_we_d;
  logic [WORD_SIZE-1:0] wb_data_d;
  logic                 wb_err_q, wb_err_d;

  // Unpack the flat register bus so selectors can index it directly.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
      assign regs_arr[gi] = regs_flat[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  assign wb_kind = sel_kind(32'(wb_sel), NUM_REGS_U);
  assign wb_hit  = wb_valid && (wb_kind == SEL_REG);

  // Returns {illegal, value} for one selector; a register hit by the
  // writeback in the same cycle takes the writeback data instead.
  function automatic logic [WORD_SIZE:0] resolve(
    input logic [SEL_W-1:0]     s,
    input logic [WORD_SIZE-1:0] reg_val,
    input logic [WORD_SIZE-1:0] imm_val,
    input logic                 byp,
    input logic [WORD_SIZE-1:0] byp_val
  );
    logic [WORD_SIZE:0] r;
    r = '0;
    case (sel_kind(32'(s), NUM_REGS_U))
      SEL_REG: r = {1'b0, (byp ? byp_val : reg_val)};
      SEL_IMM: r = {1'b0, imm_val};
      default: r = {1'b1, {WORD_SIZE{1'b0}}};
    endcase
    return r;
  endfunction

  // Operand selection and bypass for both sides of the incoming beat.
  always_comb begin
    res_a     = resolve(sel_a, regs_arr[sel_a[IDX_W-1:0]], imm,
                        wb_hit && (wb_sel == sel_a), wb_data);
    res_b     = resolve(sel_b, regs_arr[sel_b[IDX_W-1:0]], imm,
                        wb_hit && (wb_sel == sel_b), wb_data);
    op_a_d    = res_a[WORD_SIZE-1:0];
    op_b_d    = res_b[WORD_SIZE-1:0];
    sel_err_d = res_a[WORD_SIZE] | res_b[WORD_SIZE];
  end

  operand_skid_buffer #(
    .DATA_W (BEAT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel_err_d, op_b_d, op_a_d}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (beat_out)
  );

  assign op_a    = beat_out[WORD_SIZE-1:0];
  assign op_b    = beat_out[2*WORD_SIZE-1:WORD_SIZE];
  assign sel_err = beat_out[BEAT_W-1];

  // Writeback demux: one-hot enable for legal targets, error otherwise.
  always_comb begin
    wb_we_d   = '0;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_valid && (wb_kind != SEL_REG);
    if (wb_hit) begin
      wb_we_d   = NUM_REGS'(onehot(32'(wb_sel), NUM_REGS_U));
      wb_data_d = wb_data;
    end
  end

  // Writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign wb_we  = wb_we_q;
  assign wb_err = wb_err_q;

endmodule

// File: tb/tb_operand_route_unit.sv
// Bench for operand_route_unit: directed scenarios plus a randomized run,
// all checked against a queue-based model of accepted-but-unconsumed beats.
module tb_operand_route_unit;

  localparam int W  = 8;
  localparam int NR = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR*W-1:0] regs_flat = '0;
  logic [W-1:0]  imm = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] sel_a = '0;
  logic [SW-1:0] sel_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  op_a, op_b;
  logic          sel_err;
  logic          wb_valid = 1'b0;
  logic [SW-1:0] wb_sel = '0;
  logic [W-1:0]  wb_data = '0;
  logic [NR-1:0] wb_we;
  logic [W-1:0]  wb_data_q;
  logic          wb_err;

  int total = 0;
  int bad   = 0;

  // Model state: beats held by the unit, oldest first, as {err, b, a}.
  logic [2*W:0]  q[$];
  logic [NR-1:0] exp_wb_we   = '0;
  logic [W-1:0]  exp_wb_data = '0;
  logic          exp_wb_err  = 1'b0;

  always #5 clk = ~clk;

  operand_route_unit #(.WORD_SIZE(W), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .regs_flat(regs_flat), .imm(imm),
    .in_valid(in_valid), .in_ready(in_ready), .sel_a(sel_a), .sel_b(sel_b),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .sel_err(sel_err), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .wb_data(wb_data), .wb_we(wb_we), .wb_data_q(wb_data_q), .wb_err(wb_err)
  );

  // {illegal, value} an operand side should capture right now.
  function automatic logic [W:0] exp_side(input int s);
    if (s < NR) begin
      if (wb_valid && int'(wb_sel) == s) return {1'b0, wb_data};
      return {1'b0, regs_flat[s*W +: W]};
    end
    if (s == NR) return {1'b0, imm};
    return {1'b1, {W{1'b0}}};
  endfunction

  // Advance one clock and update the model: capacity two beats, FIFO order.
  task automatic tick();
    logic acc, con, legal;
    logic [W:0] a, b;
    logic [W-1:0] wd;
    int ws;
    acc   = in_valid && (q.size() < 2);
    con   = (q.size() > 0) && out_ready;
    a     = exp_side(int'(sel_a));
    b     = exp_side(int'(sel_b));
    ws    = int'(wb_sel);
    wd    = wb_data;
    legal = wb_valid && (ws < NR);
    @(posedge clk);
    #1;
    if (con) void'(q.pop_front());
    if (acc) q.push_back({a[W] | b[W], b[W-1:0], a[W-1:0]});
    exp_wb_we  = legal ? NR'(1 << ws) : '0;
    if (legal) exp_wb_data = wd;
    exp_wb_err = wb_valid && !legal;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (op_a !== 8'h00 || op_b !== 8'h00) begin bad++; $display("FAIL reset_ops got=%h/%h want=00/00", op_a, op_b); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b want=0", sel_err); end
    total++; if (wb_we !== 8'h00 || wb_data_q !== 8'h00 || wb_err !== 1'b0) begin bad++; $display("FAIL reset_wb got=%h/%h/%b want=00/00/0", wb_we, wb_data_q, wb_err); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    regs_flat = {$urandom, $urandom};
    regs_flat[3*W +: W] = 8'h11;
    imm = 8'h5A; sel_a = 4'd3; sel_b = 4'd8; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    $display("basic beat: op_a=%h op_b=%h sel_err=%b", op_a, op_b, sel_err);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (op_a !== 8'h11) begin bad++; $display("FAIL basic_op_a got=%h want=11", op_a); end
    total++; if (op_b !== 8'h5A) begin bad++; $display("FAIL basic_op_b got=%h want=5a", op_b); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL basic_sel_err got=%b want=0", sel_err); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_bypass();
    regs_flat[2*W +: W] = 8'h07;
    sel_a = 4'd2; sel_b = 4'd8; in_valid = 1'b1; out_ready = 1'b1;
    wb_valid = 1'b1; wb_sel = 4'd2; wb_data = 8'hC3;
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    $display("bypass beat: op_a=%h wb_we=%h wb_data_q=%h", op_a, wb_we, wb_data_q);
    total++; if (op_a !== 8'hC3) begin bad++; $display("FAIL bypass_op_a got=%h want=c3", op_a); end
    total++; if (wb_we !== 8'h04) begin bad++; $display("FAIL bypass_wb_we got=%h want=04", wb_we); end
    total++; if (wb_data_q !== 8'hC3) begin bad++; $display("FAIL bypass_wb_data got=%h want=c3", wb_data_q); end
    tick();
    total++; if (wb_we !== 8'h00 || wb_data_q !== 8'hC3) begin bad++; $display("FAIL wb_hold got=%h/%h want=00/c3", wb_we, wb_data_q); end
  endtask

  task automatic test_back_to_back();
    logic c_sent;
    out_ready = 1'b0; in_valid = 1'b1;
    sel_a = 4'd1; sel_b = 4'd2; tick();            // A
    regs_flat = {$urandom, $urandom};              // snapshot must not follow
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_a got=%b want=1", in_ready); end
    sel_a = 4'd4; sel_b = 4'd5; tick();            // B
    regs_flat = {$urandom, $urandom};
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_b got=%b want=0", in_ready); end
    sel_a = 4'd6; sel_b = 4'd0; tick(); tick();    // C offered, held off
    total++; if (in_ready !== 1'b0 || q.size() != 2) begin bad++; $display("FAIL b2b_hold got=%b want=0", in_ready); end
    total++; if (out_valid !== 1'b1 || {sel_err, op_b, op_a} !== q[0]) begin bad++; $display("FAIL b2b_stall got=%h want=%h", {sel_err, op_b, op_a}, q[0]); end
    out_ready = 1'b1;
    c_sent = 1'b0;
    for (int i = 0; i < 10 && (q.size() > 0 || in_valid); i++) begin
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL b2b_valid got=%b want=%b", out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        $display("b2b beat: %h", {sel_err, op_b, op_a});
        total++; if ({sel_err, op_b, op_a} !== q[0]) begin bad++; $display("FAIL b2b_order got=%h want=%h", {sel_err, op_b, op_a}, q[0]); end
      end
      if (in_valid && q.size() < 2) c_sent = 1'b1;
      tick();
      if (c_sent) in_valid = 1'b0;
    end
    total++; if (out_valid !== 1'b0 || q.size() != 0) begin bad++; $display("FAIL b2b_end got=%b want=0", out_valid); end
  endtask

  task automatic test_illegal();
    sel_a = 4'd0; sel_b = 4'd12; in_valid = 1'b1; out_ready = 1'b1;
    wb_valid = 1'b1; wb_sel = 4'd9; wb_data = 8'hAA;
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    $display("illegal beat: op_a=%h op_b=%h sel_err=%b wb_err=%b", op_a, op_b, sel_err, wb_err);
    total++; if (op_b !== 8'h00 || sel_err !== 1'b1) begin bad++; $display("FAIL illegal_sel got=%h/%b want=00/1", op_b, sel_err); end
    total++; if (op_a !== regs_flat[W-1:0]) begin bad++; $display("FAIL illegal_op_a got=%h want=%h", op_a, regs_flat[W-1:0]); end
    total++; if (wb_we !== 8'h00 || wb_err !== 1'b1) begin bad++; $display("FAIL illegal_wb got=%h/%b want=00/1", wb_we, wb_err); end
    tick();
    total++; if (wb_err !== 1'b0) begin bad++; $display("FAIL illegal_wb_pulse got=%b want=0", wb_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      regs_flat = {$urandom, $urandom};
      imm       = W'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel_a     = SW'($urandom_range(0, 15));
      sel_b     = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 15)) : SW'($urandom_range(0, 8));
      wb_valid  = $urandom_range(0, 1) == 1;
      wb_sel    = ($urandom_range(0, 1) == 1) ? sel_a : SW'($urandom_range(0, 10));
      wb_data   = W'($urandom);
      total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, in_ready, q.size() < 2); end
      total++; if (out_valid !== (q.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        if (out_ready) $display("rnd beat cyc=%0d: %h", i, {sel_err, op_b, op_a});
        total++; if ({sel_err, op_b, op_a} !== q[0]) begin bad++; $display("FAIL rnd_beat cyc=%0d got=%h want=%h", i, {sel_err, op_b, op_a}, q[0]); end
      end
      tick();
      total++; if (wb_we !== exp_wb_we || wb_err !== exp_wb_err || wb_data_q !== exp_wb_data) begin
        bad++; $display("FAIL rnd_wb cyc=%0d got=%h/%b/%h want=%h/%b/%h", i, wb_we, wb_err, wb_data_q, exp_wb_we, exp_wb_err, exp_wb_data);
      end
    end
    in_valid = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    regs_flat[W +: W] = 8'h5E;
    sel_a = 4'd1; sel_b = 4'd8;
    while (q.size() > 0) begin out_ready = 1'b1; in_valid = 1'b0; tick(); end
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; wb_valid = 1'b1; wb_sel = 4'd3; wb_data = 8'h77;
    tick();
    wb_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_a !== 8'h5E || wb_we !== 8'h08) begin
      bad++; $display("FAIL areset_pre got=%b/%b/%h/%h want=1/0/5e/08", out_valid, in_ready, op_a, wb_we);
    end
    #2 rst_n = 1'b0;
    #1;
    q.delete(); exp_wb_we = '0; exp_wb_data = '0; exp_wb_err = 1'b0;
    total++; if (out_valid !== 1'b0 || wb_we !== 8'h00 || op_a !== 8'h00) begin
      bad++; $display("FAIL areset_now got=%b/%h/%h want=0/00/00", out_valid, wb_we, op_a);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL areset_after cyc=%0d got=%b/%b want=0/1", i, out_valid, in_ready);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_back_to_back();
    test_illegal();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
